// File: rtl/time_set_if.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_if
//  Description : Key/time bundle between the key handler and the time editor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface time_set_if;
    logic [2:0] key_val;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [1:0] mode;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       load;

    modport slave (
        input  key_val, cur_hour, cur_min, cur_sec,
        output mode, set_hour, set_min, set_sec, load
    );

    modport master (
        output key_val, cur_hour, cur_min, cur_sec,
        input  mode, set_hour, set_min, set_sec, load
    );
endinterface
`default_nettype wire

// File: rtl/time_set.sv
`default_nettype none
// ============================================================================
//  Module      : time_set
//  Description : Key-driven hh:mm:ss editor with commit strobe and idle abandon.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_set #(
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  wire logic   clk,
    input  wire logic   rst,
    time_set_if.slave   bus
);

    localparam int                  c_cnt_w    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           hour_q,  hour_d;
    logic [5:0]           min_q,   min_d;
    logic [5:0]           sec_q,   sec_d;
    logic                 load_q,  load_d;
    logic [c_cnt_w-1:0]   idle_q,  idle_d;

    logic                 w_key_valid;
    logic [4:0]           w_hour_inc, w_hour_dec;
    logic [5:0]           w_min_inc,  w_min_dec;
    logic [5:0]           w_sec_inc,  w_sec_dec;

    // Explicit wrap compares keep each field inside its legal range.
    assign w_hour_inc = (hour_q == 5'd23) ? 5'd0  : hour_q + 5'd1;
    assign w_hour_dec = (hour_q == 5'd0)  ? 5'd23 : hour_q - 5'd1;
    assign w_min_inc  = (min_q  == 6'd59) ? 6'd0  : min_q  + 6'd1;
    assign w_min_dec  = (min_q  == 6'd0)  ? 6'd59 : min_q  - 6'd1;
    assign w_sec_inc  = (sec_q  == 6'd59) ? 6'd0  : sec_q  + 6'd1;
    assign w_sec_dec  = (sec_q  == 6'd0)  ? 6'd59 : sec_q  - 6'd1;

    assign w_key_valid = (bus.key_val >= 3'd1) && (bus.key_val <= 3'd4);

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        load_d  = 1'b0;
        idle_d  = idle_q;

        if (state_q == RUN) begin
            idle_d = '0;
            if (bus.key_val == 3'd1) begin
                hour_d  = bus.cur_hour;
                min_d   = bus.cur_min;
                sec_d   = bus.cur_sec;
                state_d = SET_H;
            end
        end else if (w_key_valid) begin
            // A key always wins over a coincident timeout.
            idle_d = '0;
            case (bus.key_val)
                3'd1: begin
                    case (state_q)
                        SET_H:   state_d = SET_M;
                        SET_M:   state_d = SET_S;
                        default: begin
                            state_d = RUN;
                            load_d  = 1'b1;
                        end
                    endcase
                end
                3'd2: begin
                    case (state_q)
                        SET_H:   hour_d = w_hour_inc;
                        SET_M:   min_d  = w_min_inc;
                        default: sec_d  = w_sec_inc;
                    endcase
                end
                3'd3: begin
                    case (state_q)
                        SET_H:   hour_d = w_hour_dec;
                        SET_M:   min_d  = w_min_dec;
                        default: sec_d  = w_sec_dec;
                    endcase
                end
                default: state_d = RUN;
            endcase
        end else if (idle_q == c_cnt_last) begin
            state_d = RUN;
            idle_d  = '0;
        end else begin
            idle_d = idle_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            hour_q  <= 5'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            load_q  <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            load_q  <= load_d;
            idle_q  <= idle_d;
        end
    end

    assign bus.mode     = state_q;
    assign bus.set_hour = hour_q;
    assign bus.set_min  = min_q;
    assign bus.set_sec  = sec_q;
    assign bus.load     = load_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_set
//  Description : Scenario bench for time_set with an expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set;

    typedef struct packed {
        logic [1:0] mode;
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic       load;
    } snap_t;

    typedef struct {
        logic [2:0] key;
        logic       rst;
        snap_t      exp;
    } step_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     n_checks = 0;
    int     n_fail   = 0;
    snap_t  exp_q [$];
    step_t  plan  [$];

    time_set_if bus ();

    time_set #(.TIMEOUT_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(int m, int h, int mi, int s, int l);
        snap_t r;
        r.mode = 2'(m);
        r.hour = 5'(h);
        r.min  = 6'(mi);
        r.sec  = 6'(s);
        r.load = 1'(l);
        return r;
    endfunction

    function automatic snap_t snap_now();
        snap_t r;
        r.mode = bus.mode;
        r.hour = bus.set_hour;
        r.min  = bus.set_min;
        r.sec  = bus.set_sec;
        r.load = bus.load;
        return r;
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("mode=%0d %0d:%0d:%0d load=%0b", s.mode, s.hour, s.min, s.sec, s.load);
    endfunction

    function automatic void add(int k, int r, snap_t e);
        step_t st;
        st.key = 3'(k);
        st.rst = 1'(r);
        st.exp = e;
        plan.push_back(st);
    endfunction

    task automatic set_cur(int h, int m, int s);
        bus.cur_hour = 5'(h);
        bus.cur_min  = 6'(m);
        bus.cur_sec  = 6'(s);
    endtask

    // Drives one cycle of the plan and queues the state expected after the edge.
    task automatic run_step(int i);
        exp_q.push_back(plan[i].exp);
        rst         = plan[i].rst;
        bus.key_val = plan[i].key;
        @(posedge clk);
        #1;
        bus.key_val = 3'd0;
        rst         = 1'b0;
    endtask

    task automatic test_reset();
        snap_t got, e;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        got = snap_now();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_held: got %s, expected %s", fmt(got), fmt(e));
        end
        plan.delete();
        add(0, 0, mk(0, 0, 0, 0, 0));
        add(2, 0, mk(0, 0, 0, 0, 0));
        foreach (plan[i]) begin
            run_step(i);
            got = snap_now();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_release step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_full_commit();
        snap_t got, e;
        set_cur(12, 34, 56);
        plan.delete();
        add(1, 0, mk(1, 12, 34, 56, 0));
        add(2, 0, mk(1, 13, 34, 56, 0));
        add(2, 0, mk(1, 14, 34, 56, 0));
        add(1, 0, mk(2, 14, 34, 56, 0));
        add(3, 0, mk(2, 14, 33, 56, 0));
        add(1, 0, mk(3, 14, 33, 56, 0));
        add(2, 0, mk(3, 14, 33, 57, 0));
        add(1, 0, mk(0, 14, 33, 57, 1));
        add(0, 0, mk(0, 14, 33, 57, 0));
        foreach (plan[i]) begin
            run_step(i);
            if (i == 0) set_cur(1, 2, 3);
            got = snap_now();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL full_commit step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_wrap();
        snap_t got, e;
        set_cur(23, 59, 0);
        plan.delete();
        add(1, 0, mk(1, 23, 59, 0, 0));
        add(2, 0, mk(1, 0, 59, 0, 0));
        add(3, 0, mk(1, 23, 59, 0, 0));
        add(2, 0, mk(1, 0, 59, 0, 0));
        add(1, 0, mk(2, 0, 59, 0, 0));
        add(2, 0, mk(2, 0, 0, 0, 0));
        add(3, 0, mk(2, 0, 59, 0, 0));
        add(2, 0, mk(2, 0, 0, 0, 0));
        add(1, 0, mk(3, 0, 0, 0, 0));
        add(3, 0, mk(3, 0, 0, 59, 0));
        add(2, 0, mk(3, 0, 0, 0, 0));
        add(3, 0, mk(3, 0, 0, 59, 0));
        add(4, 0, mk(0, 0, 0, 59, 0));
        foreach (plan[i]) begin
            run_step(i);
            got = snap_now();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL wrap step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_cancel();
        snap_t got, e;
        set_cur(5, 6, 7);
        plan.delete();
        add(1, 0, mk(1, 5, 6, 7, 0));
        add(2, 0, mk(1, 6, 6, 7, 0));
        add(4, 0, mk(0, 6, 6, 7, 0));
        add(0, 0, mk(0, 6, 6, 7, 0));
        add(0, 0, mk(0, 6, 6, 7, 0));
        foreach (plan[i]) begin
            run_step(i);
            got = snap_now();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL cancel step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_timeout();
        snap_t got, e;
        set_cur(10, 20, 30);
        plan.delete();
        // First pass: idle out of SET_M 16 cycles after the last key.
        add(1, 0, mk(1, 10, 20, 30, 0));
        add(1, 0, mk(2, 10, 20, 30, 0));
        for (int j = 0; j < 15; j++) add(0, 0, mk(2, 10, 20, 30, 0));
        add(0, 0, mk(0, 10, 20, 30, 0));
        // Second pass: a key on the timeout cycle keeps the edit alive.
        add(1, 0, mk(1, 10, 20, 30, 0));
        add(1, 0, mk(2, 10, 20, 30, 0));
        for (int j = 0; j < 15; j++) add(0, 0, mk(2, 10, 20, 30, 0));
        add(2, 0, mk(2, 10, 21, 30, 0));
        for (int j = 0; j < 15; j++) add(0, 0, mk(2, 10, 21, 30, 0));
        add(0, 0, mk(0, 10, 21, 30, 0));
        foreach (plan[i]) begin
            run_step(i);
            got = snap_now();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL timeout step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_ignored();
        snap_t got, e;
        set_cur(3, 4, 5);
        plan.delete();
        add(5, 0, mk(0, 10, 21, 30, 0));
        add(6, 0, mk(0, 10, 21, 30, 0));
        add(7, 0, mk(0, 10, 21, 30, 0));
        add(2, 0, mk(0, 10, 21, 30, 0));
        add(3, 0, mk(0, 10, 21, 30, 0));
        add(4, 0, mk(0, 10, 21, 30, 0));
        for (int st = 1; st <= 3; st++) begin
            add(1, 0, mk(st, 3, 4, 5, 0));
            for (int k = 5; k <= 7; k++) add(k, 0, mk(st, 3, 4, 5, 0));
        end
        foreach (plan[i]) begin
            run_step(i);
            got = snap_now();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL ignored step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid_edit();
        snap_t got, e;
        plan.delete();
        add(1, 1, mk(0, 0, 0, 0, 0));
        add(0, 0, mk(0, 0, 0, 0, 0));
        add(0, 0, mk(0, 0, 0, 0, 0));
        foreach (plan[i]) begin
            run_step(i);
            got = snap_now();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_mid_edit step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    initial begin
        bus.key_val = 3'd0;
        set_cur(0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_full_commit();
        test_wrap();
        test_cancel();
        test_timeout();
        test_ignored();
        test_reset_mid_edit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/time_set.md
TIME_SET -- requirements
Module: time_set

Interface
REQ-001 Parameter TIMEOUT_CYC, default 500_000_000: idle cycles in an edit state before automatic abandon (10 s at 50 MHz).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 key_val  input  3  debounced key event; 0 = none, 1..4 = key code, valid for one cycle; 5..7 never expected.
REQ-005 cur_hour  input  5  running hour, 0..23.
REQ-006 cur_min  input  6  running minute, 0..59.
REQ-007 cur_sec  input  6  running second, 0..59.
REQ-008 mode  output  2  edit state: 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S.
REQ-009 set_hour  output  5  edited hour (shadow register).
REQ-010 set_min  output  6  edited minute (shadow register).
REQ-011 set_sec  output  6  edited second (shadow register).
REQ-012 load  output  1  one-cycle commit strobe; set_* valid while high.

Function
REQ-013 The FSM SHALL have exactly four states: RUN, SET_H, SET_M, SET_S.
- mode encodes the current state directly.
REQ-014 In RUN, key 1 SHALL copy cur_hour/min/sec into the shadows and enter SET_H on the next edge.
- Keys 2..4 in RUN are ignored.
REQ-015 Key 1 SHALL advance the edit state: SET_H->SET_M->SET_S.
- In SET_S, key 1 SHALL return to RUN and assert load for exactly one cycle.
- load is registered: it goes high on the same edge on which mode becomes 0.
REQ-016 Key 2 in an edit state SHALL increment the selected field.
- Hour wraps 23->0; minute and second wrap 59->0.
REQ-017 Key 3 in an edit state SHALL decrement the selected field.
- Hour wraps 0->23; minute and second wrap 0->59.
REQ-018 Key 4 in an edit state SHALL return to RUN without asserting load; shadows are left unchanged.
REQ-019 key_val values 0 and 5..7 SHALL be treated as no event in every state.
REQ-020 Each key event SHALL affect the design exactly once.
- The state change or shadow update is visible one cycle after the key_val pulse.
REQ-021 An idle counter SHALL run only in edit states.
- It clears on any valid key (1..4) and on entry to RUN.
- When it reaches TIMEOUT_CYC-1 with no key that cycle, the FSM returns to RUN with load low (abandon).
REQ-022 A valid key arriving in the same cycle as the timeout SHALL take priority; the counter clears.
REQ-023 Only the field selected by mode SHALL change; the other shadows hold.
REQ-024 Shadows SHALL hold their values in RUN so downstream can still read the last committed set.
REQ-025 load SHALL be low in every cycle other than the commit cycle defined in REQ-015.
REQ-026 cur_* inputs SHALL be sampled only on RUN->SET_H entry.
- Changes to cur_* during editing have no effect.
REQ-027 Counter width SHALL be ceil(log2(TIMEOUT_CYC)) bits.
- Field arithmetic SHALL be done at field width with explicit wrap compares, never relying on modulo overflow.

Reset
REQ-028 While rst=1 at a clock edge, outputs SHALL take these values: mode=0, set_hour=0, set_min=0, set_sec=0, load=0, idle counter=0.
REQ-029 rst asserted mid-edit SHALL discard the edit: no load pulse, state RUN on the following cycle.
REQ-030 rst SHALL take priority over key_val and over the timeout.

Verification
REQ-031 Full commit, cur=12:34:56.
- Stimulus: key 1; key 2 x2; key 1; key 3; key 1; key 2; key 1.
- Required: mode steps 1,2,3,0; single load pulse with set = 14:33:57.
REQ-032 Wrap at boundaries.
- cur=23:59:00, enter SET_H, key 2 -> hour 0.
- Advance to SET_M, key 2 -> min 0.
- Advance to SET_S, key 3 -> sec 59.
REQ-033 Cancel.
- cur=05:06:07, enter SET_H, key 2 -> hour 6; key 4.
- Required: mode=0, load never high, set_hour stays 6.
REQ-034 Timeout with TIMEOUT_CYC=16.
- Enter SET_M and hold idle -> mode=0 exactly 16 cycles after the last key, load=0.
- Repeat with key 2 on the timeout cycle -> stays in SET_M and min increments.
REQ-035 Ignored codes.
- key_val=5,6,7 in each state -> no state or shadow change.
- keys 2/3/4 in RUN -> no change.
REQ-036 Reset mid-edit.
- In SET_S, assert rst one cycle together with key 1.
- Required: all outputs zero, no load pulse, mode=0.
